frame_value_sweeper: RTL and testbench

- Multi-channel, frame-synchronous value generator for the on-screen menu test path.
- Each channel advances a VAL_W-bit value once every (div+1) video frames, with per-channel limits, step size and sweep mode.
- Outputs feed the binary-to-decimal converters that drive the menu ROM fields.
- Replaces hard-coded per-field animation counters with one parametrised block; adds limits, step size, four sweep modes, enable/reload control and step strobes.

---
 rtl/frame_value_sweeper.sv | 95 +++++++++
 tb/tb_frame_value_sweeper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_value_sweeper.sv
// frame_value_sweeper: per-channel frame-divided value generator with limits, step size,
// four sweep modes, reload/enable control and step strobes.
module frame_value_sweeper #(
    parameter int NUM_CH = 2,
    parameter int VAL_W  = 16,
    parameter int DIV_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    newframe,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*VAL_W-1:0] cfg_min,
    input  logic [NUM_CH*VAL_W-1:0] cfg_max,
    input  logic [NUM_CH*VAL_W-1:0] cfg_step,
    input  logic [NUM_CH*2-1:0]     cfg_mode,
    output logic [NUM_CH*VAL_W-1:0] value,
    output logic [NUM_CH-1:0]       step_pulse,
    output logic [NUM_CH-1:0]       dir_down
);
    logic newframe_q, tick;

    // Resetting to 1 keeps a newframe held high through reset release from ticking.
    always_ff @(posedge clk or negedge rst)
        if (!rst) newframe_q <= 1'b1;
        else newframe_q <= newframe;

    assign tick = newframe & ~newframe_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [VAL_W-1:0] mn, mx, st, v, v_nxt;
        logic [DIV_W-1:0] dv, cnt;
        logic [1:0]       md;
        logic [VAL_W:0]   sum, lim;
        logic dd, dd_nxt, sp, invalid, out_of_range, down, up_ovf, dn_unf;

        assign mn           = cfg_min[c*VAL_W +: VAL_W];
        assign mx           = cfg_max[c*VAL_W +: VAL_W];
        assign st           = cfg_step[c*VAL_W +: VAL_W];
        assign dv           = cfg_div[c*DIV_W +: DIV_W];
        assign md           = cfg_mode[c*2 +: 2];
        assign sum          = {1'b0, v} + {1'b0, st};
        assign lim          = {1'b0, mn} + {1'b0, st};
        assign up_ovf       = sum > {1'b0, mx};
        assign dn_unf       = {1'b0, v} < lim;
        assign invalid      = mn > mx;
        assign out_of_range = v < mn || v > mx;
        assign down         = md == 2'd3 || (md == 2'd2 && dd);

        always_comb begin
            v_nxt  = v;
            dd_nxt = dd;
            if (invalid) v_nxt = mn;
            else if (st != '0) begin
                if (out_of_range) v_nxt = down ? mx : mn;
                else if (down) begin
                    v_nxt  = dn_unf ? (md == 2'd2 ? mn : mx) : v - st;
                    dd_nxt = md == 2'd2 ? ~dn_unf : dd;
                end else begin
                    v_nxt  = up_ovf ? (md == 2'd0 ? mn : mx) : sum[VAL_W-1:0];
                    dd_nxt = md == 2'd2 ? up_ovf : dd;
                end
            end
        end

        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                v   <= '0;
                cnt <= '0;
                dd  <= 1'b0;
                sp  <= 1'b0;
            end else if (load[c]) begin
                v   <= (md == 2'd3 && !invalid) ? mx : mn;
                cnt <= '0;
                dd  <= md == 2'd3;
                sp  <= 1'b0;
            end else begin
                sp <= 1'b0;
                if (en[c] && tick) begin
                    if (cnt != dv) cnt <= cnt + DIV_W'(1);
                    else begin
                        cnt <= '0;
                        v   <= v_nxt;
                        dd  <= dd_nxt;
                        sp  <= !invalid && v_nxt != v;
                    end
                end
            end

        assign value[c*VAL_W +: VAL_W] = v;
        assign step_pulse[c]           = sp;
        assign dir_down[c]             = dd;
    end
endmodule

// File: tb/tb_frame_value_sweeper.sv
// tb_frame_value_sweeper: directed stimulus with an independent channel model feeding a
// scoreboard queue that is drained and compared after each DUT update.
module tb_frame_value_sweeper;
    localparam int NUM_CH = 2;
    localparam int VAL_W  = 16;
    localparam int DIV_W  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic newframe = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic [NUM_CH-1:0] load = '0;
    logic [NUM_CH*DIV_W-1:0] cfg_div;
    logic [NUM_CH*VAL_W-1:0] cfg_min, cfg_max, cfg_step;
    logic [NUM_CH*2-1:0]     cfg_mode;
    logic [NUM_CH*VAL_W-1:0] value;
    logic [NUM_CH-1:0]       step_pulse, dir_down;

    logic [VAL_W-1:0] mn[NUM_CH], mx[NUM_CH], st[NUM_CH];
    logic [DIV_W-1:0] dv[NUM_CH];
    logic [1:0]       md[NUM_CH];

    always_comb
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_div[i*DIV_W +: DIV_W]  = dv[i];
            cfg_min[i*VAL_W +: VAL_W]  = mn[i];
            cfg_max[i*VAL_W +: VAL_W]  = mx[i];
            cfg_step[i*VAL_W +: VAL_W] = st[i];
            cfg_mode[i*2 +: 2]         = md[i];
        end

    frame_value_sweeper #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .newframe(newframe), .en(en), .load(load),
        .cfg_div(cfg_div), .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step),
        .cfg_mode(cfg_mode), .value(value), .step_pulse(step_pulse), .dir_down(dir_down)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int val; bit p; bit dd;} exp_t;
    exp_t sb[$];
    int m_val[NUM_CH], m_dc[NUM_CH];
    bit m_dd[NUM_CH], m_p[NUM_CH];
    int compared = 0, mismatched = 0;
    int pulses0 = 0;

    always @(negedge clk) if (step_pulse[0]) pulses0++;

    task automatic cmp(input string tag, input int ch, input int obs, input int exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s ch%0d: got %0d want %0d", tag, ch, obs, exp_v);
        end
    endtask

    task automatic push_all();
        for (int c = 0; c < NUM_CH; c++) sb.push_back('{c, m_val[c], m_p[c], m_dd[c]});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({tag, ".value"}, e.ch, int'(value[e.ch*VAL_W +: VAL_W]), e.val);
            cmp({tag, ".step_pulse"}, e.ch, int'(step_pulse[e.ch]), int'(e.p));
            cmp({tag, ".dir_down"}, e.ch, int'(dir_down[e.ch]), int'(e.dd));
        end
    endtask

    function automatic void m_load(input int c);
        m_val[c] = (md[c] == 2'd3 && mn[c] <= mx[c]) ? int'(mx[c]) : int'(mn[c]);
        m_dc[c]  = 0;
        m_dd[c]  = md[c] == 2'd3;
        m_p[c]   = 0;
    endfunction

    function automatic void m_tick(input int c);
        int v, a, b, s, n;
        bit oor;
        m_p[c] = 0;
        if (!en[c]) return;
        if (m_dc[c] != int'(dv[c])) begin
            m_dc[c]++;
            return;
        end
        m_dc[c] = 0;
        v = m_val[c]; a = int'(mn[c]); b = int'(mx[c]); s = int'(st[c]);
        oor = v < a || v > b;
        n = v;
        if (a > b) n = a;
        else if (s != 0)
            case (md[c])
                2'd0: n = oor ? a : (v + s > b ? a : v + s);
                2'd1: n = oor ? a : (v + s > b ? b : v + s);
                2'd3: n = oor ? b : (v - s < a ? b : v - s);
                default:
                    if (!m_dd[c]) begin
                        n = oor ? a : (v + s > b ? b : v + s);
                        if (!oor && v + s > b) m_dd[c] = 1;
                    end else begin
                        n = oor ? b : (v - s < a ? a : v - s);
                        if (!oor && v - s < a) m_dd[c] = 0;
                    end
            endcase
        m_p[c]   = a <= b && n != v;
        m_val[c] = n;
    endfunction

    task automatic idle_check();
        for (int c = 0; c < NUM_CH; c++) m_p[c] = 0;
        push_all();
        @(negedge clk);
        pop_check("idle");
    endtask

    task automatic frame();
        @(negedge clk);
        newframe = 1'b1;
        for (int c = 0; c < NUM_CH; c++) m_tick(c);
        push_all();
        @(negedge clk);
        newframe = 1'b0;
        pop_check("frame");
        idle_check();
    endtask

    task automatic do_load(input logic [NUM_CH-1:0] mask, input bit with_tick);
        @(negedge clk);
        load = mask;
        newframe = with_tick;
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c]) m_load(c);
            else if (with_tick) m_tick(c);
            else m_p[c] = 0;
        push_all();
        @(negedge clk);
        load = '0;
        newframe = 1'b0;
        pop_check(with_tick ? "load_tick" : "load");
        idle_check();
    endtask

    function automatic void cfg(input int c, input int a, input int b, input int s, input int d, input int m);
        mn[c] = VAL_W'(a); mx[c] = VAL_W'(b); st[c] = VAL_W'(s); dv[c] = DIV_W'(d); md[c] = 2'(m);
    endfunction

    initial begin
        int pp_val[7] = '{14, 18, 20, 16, 12, 10, 14};
        int pp_dd[7]  = '{0, 0, 1, 1, 1, 0, 0};
        int wd_val[3] = '{25, 10, 40};
        for (int c = 0; c < NUM_CH; c++) begin
            cfg(c, 0, 10, 1, 0, 0);
            m_val[c] = 0; m_dc[c] = 0; m_dd[c] = 0; m_p[c] = 0;
        end
        en = 2'b11;
        newframe = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        push_all();
        pop_check("reset");
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            push_all();
            pop_check("nf_high_after_reset");
        end
        newframe = 1'b0;
        idle_check();

        cfg(0, 0, 77, 1, 50, 0);
        do_load(2'b01, 0);
        pulses0 = 0;
        for (int i = 0; i < 51 * 80; i++) begin
            frame();
            if (i == 77 * 51 - 1) cmp("wrap_up_at_max", 0, int'(value[15:0]), 77);
            if (i == 78 * 51 - 1) cmp("wrap_up_to_min", 0, int'(value[15:0]), 0);
        end
        cmp("wrap_up_pulse_count", 0, pulses0, 80);
        cmp("wrap_up_final", 0, int'(value[15:0]), 2);

        cfg(1, 10, 20, 4, 0, 2);
        do_load(2'b10, 0);
        cmp("pingpong_load", 1, int'(value[31:16]), 10);
        for (int i = 0; i < 7; i++) begin
            frame();
            cmp("pingpong_seq", 1, int'(value[31:16]), pp_val[i]);
            cmp("pingpong_dir", 1, int'(dir_down[1]), pp_dd[i]);
        end

        cfg(0, 16'hFFF0, 16'hFFFF, 16'h8000, 0, 1);
        do_load(2'b01, 0);
        mn[0] = '0;
        frame();
        cmp("sat_up_clamp", 0, int'(value[15:0]), 16'hFFFF);
        pulses0 = 0;
        frame();
        frame();
        cmp("sat_up_hold", 0, int'(value[15:0]), 16'hFFFF);
        cmp("sat_up_no_pulse", 0, pulses0, 0);

        cfg(1, 0, 100, 5, 2, 0);
        do_load(2'b10, 0);
        frame();
        frame();
        do_load(2'b10, 1);
        cmp("load_tick_value", 1, int'(value[31:16]), 0);
        frame();
        frame();
        cmp("div_restart_hold", 1, int'(value[31:16]), 0);
        frame();
        cmp("div_restart_step", 1, int'(value[31:16]), 5);
        en = 2'b01;
        repeat (5) frame();
        cmp("en_off_frozen", 1, int'(value[31:16]), 5);
        en = 2'b11;

        cfg(0, 30, 20, 1, 0, 0);
        do_load(2'b01, 0);
        cmp("invalid_load", 0, int'(value[15:0]), 30);
        pulses0 = 0;
        repeat (10) frame();
        cmp("invalid_no_pulse", 0, pulses0, 0);
        cfg(0, 10, 40, 15, 0, 3);
        do_load(2'b01, 0);
        cmp("wrap_down_load", 0, int'(value[15:0]), 40);
        for (int i = 0; i < 3; i++) begin
            frame();
            cmp("wrap_down_seq", 0, int'(value[15:0]), wd_val[i]);
        end

        md[0] = 2'd0;
        mx[0] = 16'd30;
        frame();
        cmp("out_of_range_to_min", 0, int'(value[15:0]), 10);
        st[0] = '0;
        repeat (3) frame();
        cmp("step_zero_hold", 0, int'(value[15:0]), 10);

        st[0] = 16'd1;
        repeat (4) frame();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_val[c] = 0; m_dc[c] = 0; m_dd[c] = 0; m_p[c] = 0;
        end
        push_all();
        pop_check("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
